// File: rtl/adunare_pkg.sv
// Shared definitions for the pipelined adunare adder/subtractor.
// Provides the chunk-width helper, parameter legality check and flag struct.
package adunare_pkg;

   localparam int unsigned MAX_STAGES = 16;

   typedef struct packed {
      logic cout;
      logic ovf;
   } adunare_flags_t;

   function automatic int unsigned chunk(input int unsigned width, input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

   function automatic bit params_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (stages <= MAX_STAGES) && (width > 0) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adunare_stage.sv
// One CHUNK-bit slice of the pipelined adder: registered sum chunk, carry out,
// carry into the chunk MSB (for signed overflow) and valid bit, all gated by i_en.
module adunare_stage #(
   parameter int unsigned CH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_en,
   input  logic          i_valid,
   input  logic [CH-1:0] i_a,
   input  logic [CH-1:0] i_b,
   input  logic          i_cin,
   output logic          o_valid,
   output logic [CH-1:0] o_sum,
   output logic          o_cout,
   output logic          o_cmsb
);

   logic [CH:0] w_full;
   logic        w_cmsb;

   logic          r_valid;
   logic [CH-1:0] r_sum;
   logic          r_cout;
   logic          r_cmsb;

   // Carry into the MSB recovered from the sum bit and the two operand bits.
   always_comb begin
      w_full = {1'b0, i_a} + {1'b0, i_b} + {{CH{1'b0}}, i_cin};
      w_cmsb = w_full[CH-1] ^ i_a[CH-1] ^ i_b[CH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_cmsb  <= 1'b0;
      end else if (i_en) begin
         r_valid <= i_valid;
         r_sum   <= w_full[CH-1:0];
         r_cout  <= w_full[CH];
         r_cmsb  <= w_cmsb;
      end
   end

   assign o_valid = r_valid;
   assign o_sum   = r_sum;
   assign o_cout  = r_cout;
   assign o_cmsb  = r_cmsb;

endmodule

// File: rtl/adunare_pipe.sv
// Parametrised pipelined adder/subtractor: STAGES chunk slices, LSB chunk first,
// with operand skew / sum deskew registers and a whole-pipeline valid/ready stall.
module adunare_pipe
   import adunare_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned CH = chunk(WIDTH, STAGES);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      adunare_flags_t   flags;
   } res_t;

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $error("adunare_pipe: WIDTH must be a multiple of STAGES and STAGES must be 1..16");
   end

   logic             w_en;
   logic [WIDTH-1:0] r_opa [STAGES];
   logic [WIDTH-1:0] r_opb [STAGES];
   logic [WIDTH-1:0] r_lo  [STAGES];
   logic [WIDTH-1:0] w_opa [STAGES];
   logic [WIDTH-1:0] w_opb [STAGES];
   logic [WIDTH-1:0] w_lo  [STAGES];
   logic [WIDTH-1:0] w_cat [STAGES];
   logic [CH-1:0]    w_chunk [STAGES];
   logic             w_vin  [STAGES];
   logic             w_cin  [STAGES];
   logic             w_vout [STAGES];
   logic             w_cout [STAGES];
   logic             w_cmsb [STAGES];
   res_t             w_res;

   assign w_en     = !w_vout[STAGES-1] || out_ready;
   assign in_ready = w_en;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      if (k == 0) begin : g_first
         assign w_opa[k] = in_a;
         assign w_opb[k] = in_sub ? ~in_b : in_b;
         assign w_vin[k] = in_valid;
         assign w_cin[k] = in_cin ^ in_sub;
         assign w_lo[k]  = '0;
      end else begin : g_next
         // Skew registers keep the next unconsumed chunk in the low bits.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_opa[k] <= '0;
               r_opb[k] <= '0;
               r_lo[k]  <= '0;
            end else if (w_en) begin
               r_opa[k] <= w_opa[k-1] >> CH;
               r_opb[k] <= w_opb[k-1] >> CH;
               r_lo[k]  <= w_cat[k-1];
            end
         end
         assign w_opa[k] = r_opa[k];
         assign w_opb[k] = r_opb[k];
         assign w_vin[k] = w_vout[k-1];
         assign w_cin[k] = w_cout[k-1];
         assign w_lo[k]  = r_lo[k];
      end

      adunare_stage #(.CH(CH)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (w_en),
         .i_valid (w_vin[k]),
         .i_a     (w_opa[k][CH-1:0]),
         .i_b     (w_opb[k][CH-1:0]),
         .i_cin   (w_cin[k]),
         .o_valid (w_vout[k]),
         .o_sum   (w_chunk[k]),
         .o_cout  (w_cout[k]),
         .o_cmsb  (w_cmsb[k])
      );

      // Deskewed bits above chunk k are always zero, so OR merges the new chunk.
      assign w_cat[k] = w_lo[k] | (WIDTH'(w_chunk[k]) << (k * CH));
   end

   assign w_res.sum        = w_cat[STAGES-1];
   assign w_res.flags.cout = w_cout[STAGES-1];
   assign w_res.flags.ovf  = w_cout[STAGES-1] ^ w_cmsb[STAGES-1];

   assign out_valid = w_vout[STAGES-1];
   assign out_sum   = w_res.sum;
   assign out_cout  = w_res.flags.cout;
   assign out_ovf   = w_res.flags.ovf;

endmodule

// File: tb/tb_adunare_pipe.sv
// Directed and streamed checks of adunare_pipe at 64/4, 8/1 and 32/8.
module tb_adunare_pipe;

   localparam int unsigned TW [3] = '{64, 8, 32};
   localparam int unsigned TS [3] = '{4, 1, 8};

   typedef struct packed {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid  [3];
   logic        in_cin    [3];
   logic        in_sub    [3];
   logic        out_ready [3];
   logic [63:0] in_a      [3];
   logic [63:0] in_b      [3];
   logic        in_ready  [3];
   logic        out_valid [3];
   logic        out_cout  [3];
   logic        out_ovf   [3];
   logic [63:0] out_sum   [3];
   logic [63:0] sum64;
   logic [7:0]  sum8;
   logic [31:0] sum32;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   assign out_sum[0] = sum64;
   assign out_sum[1] = {56'd0, sum8};
   assign out_sum[2] = {32'd0, sum32};

   adunare_pipe #(.WIDTH(64), .STAGES(4)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]), .in_sub(in_sub[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(sum64),
      .out_cout(out_cout[0]), .out_ovf(out_ovf[0])
   );

   adunare_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a[1][7:0]), .in_b(in_b[1][7:0]), .in_cin(in_cin[1]), .in_sub(in_sub[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum8),
      .out_cout(out_cout[1]), .out_ovf(out_ovf[1])
   );

   adunare_pipe #(.WIDTH(32), .STAGES(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_a(in_a[2][31:0]), .in_b(in_b[2][31:0]), .in_cin(in_cin[2]), .in_sub(in_sub[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(sum32),
      .out_cout(out_cout[2]), .out_ovf(out_ovf[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Reference: whole-width add, overflow from operand/result signs.
   function automatic exp_t ref_add(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub);
      logic [63:0] mask, aa, bb;
      logic [64:0] full;
      exp_t        r;
      mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      aa     = a & mask;
      bb     = (sub ? ~b : b) & mask;
      full   = {1'b0, aa} + {1'b0, bb} + 65'(cin ^ sub);
      r.sum  = full[63:0] & mask;
      r.cout = full[w];
      r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
      return r;
   endfunction

   // Called at posedge+1: present one beat, measure edges until out_valid, check result.
   task automatic run_one(input int d, input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic sub, input logic [63:0] es, input logic ec, input logic eo,
                          input string tag);
      int unsigned lat;
      in_a[d] = a; in_b[d] = b; in_cin[d] = cin; in_sub[d] = sub;
      in_valid[d] = 1'b1; out_ready[d] = 1'b1;
      #1;
      chk({tag, "_in_ready"}, 64'(in_ready[d]), 64'd1);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      lat = 1;
      while (!out_valid[d] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(TS[d]));
      chk({tag, "_sum"},  out_sum[d],        es);
      chk({tag, "_cout"}, 64'(out_cout[d]),  64'(ec));
      chk({tag, "_ovf"},  64'(out_ovf[d]),   64'(eo));
      @(posedge clk); #1;
      chk({tag, "_drain"}, 64'(out_valid[d]), 64'd0);
   endtask

   logic [63:0] sa [20];
   logic [63:0] sb [20];
   logic        scin [20];
   logic        ssub [20];
   exp_t        sexp [20];

   initial begin
      int unsigned sent, recv, cyc;
      logic        acc, stall;
      exp_t        snap, e;
      logic [63:0] ra, rb, mask;
      logic        rc, rs;

      for (int d = 0; d < 3; d++) begin
         in_valid[d] = 1'b0; in_cin[d] = 1'b0; in_sub[d] = 1'b0; out_ready[d] = 1'b1;
         in_a[d] = '0; in_b[d] = '0;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst%0d_valid", d), 64'(out_valid[d]), 64'd0);
         chk($sformatf("rst%0d_ready", d), 64'(in_ready[d]),  64'd1);
         chk($sformatf("rst%0d_sum",   d), out_sum[d],        64'd0);
         chk($sformatf("rst%0d_flags", d), {62'd0, out_cout[d], out_ovf[d]}, 64'd0);
      end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, 64-bit / 4 stages.
      run_one(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, "wrap");
      run_one(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "sovf");
      run_one(0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
      run_one(0, 64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, "sub_cin");
      run_one(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, "chunk_carry");
      run_one(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, "neg_ovf");
      run_one(0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, "cin_only");
      run_one(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sub_ovf");

      // Stream with pseudo-random back-pressure.
      for (int i = 0; i < 20; i++) begin
         sa[i] = {$urandom, $urandom}; sb[i] = {$urandom, $urandom};
         scin[i] = 1'($urandom_range(0, 1)); ssub[i] = 1'($urandom_range(0, 1));
         sexp[i] = ref_add(64, sa[i], sb[i], scin[i], ssub[i]);
      end
      sent = 0; recv = 0; cyc = 0; snap = '0;
      while (recv < 20 && cyc < 400) begin
         in_valid[0] = (sent < 20);
         if (sent < 20) begin
            in_a[0] = sa[sent]; in_b[0] = sb[sent]; in_cin[0] = scin[sent]; in_sub[0] = ssub[sent];
         end
         out_ready[0] = 1'($urandom_range(0, 1));
         #1;
         acc   = in_valid[0] && in_ready[0];
         stall = out_valid[0] && !out_ready[0];
         if (out_valid[0] && out_ready[0]) begin
            chk($sformatf("s%0d_sum", recv), out_sum[0], sexp[recv].sum);
            chk($sformatf("s%0d_flags", recv), {62'd0, out_cout[0], out_ovf[0]},
                {62'd0, sexp[recv].cout, sexp[recv].ovf});
            recv++;
         end
         if (stall) begin
            snap = '{sum: out_sum[0], cout: out_cout[0], ovf: out_ovf[0]};
            chk("stall_in_ready", 64'(in_ready[0]), 64'd0);
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) sent++;
         if (stall) begin
            chk("stall_sum", out_sum[0], snap.sum);
            chk("stall_flags", {61'd0, out_valid[0], out_cout[0], out_ovf[0]},
                {61'd0, 1'b1, snap.cout, snap.ovf});
         end
      end
      chk("stream_count", 64'(recv), 64'd20);
      in_valid[0] = 1'b0; out_ready[0] = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("stream_no_dup", 64'(out_valid[0]), 64'd0);
      end

      // Reset with three beats in flight and the head beat stalled at the output.
      out_ready[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a[0] = 64'(100 + i); in_b[0] = 64'd1; in_cin[0] = 1'b0; in_sub[0] = 1'b0;
         in_valid[0] = 1'b1;
         @(posedge clk); #1;
      end
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_valid", 64'(out_valid[0]), 64'd1);
      chk("pre_rst_sum", out_sum[0], 64'd101);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid[0]), 64'd0);
      chk("mid_rst_ready", 64'(in_ready[0]),  64'd1);
      chk("mid_rst_sum",   out_sum[0],        64'd0);
      #12 rst_n = 1'b1;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      repeat (4) begin
         chk("post_rst_stale", 64'(out_valid[0]), 64'd0);
         @(posedge clk); #1;
      end
      run_one(0, 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0, "post_rst");

      // Parameter sweep against the reference model.
      for (int d = 1; d < 3; d++) begin
         mask = (64'd1 << TW[d]) - 64'd1;
         for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom} & mask;
            rb = {$urandom, $urandom} & mask;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            e  = ref_add(TW[d], ra, rb, rc, rs);
            run_one(d, ra, rb, rc, rs, e.sum, e.cout, e.ovf, $sformatf("w%0d_%0d", TW[d], i));
         end
      end
      run_one(1, 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, "w8_ovf");
      run_one(2, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, "w32_wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule
